// File: rtl/lcd_de_capture_pkg.sv
// Shared types for the DE-mode panel capture path: FSM states, the tagged
// pixel record carried through the output FIFO, and coordinate helpers.
package lcd_de_capture_pkg;

  localparam int RGB_W   = 24;
  localparam int COORD_W = 10;
  localparam int TAG_W   = RGB_W + 2 * COORD_W + 2;

  localparam logic [COORD_W-1:0] COORD_MAX = '1;

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_VBLANK = 2'd1,
    ST_LINE   = 2'd2,
    ST_HGAP   = 2'd3
  } rx_state_e;

  typedef struct packed {
    logic [RGB_W-1:0]   rgb;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               sof;
    logic               eol;
  } pix_tag_t;

  function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v);
    return (v == COORD_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rx_pixel_fifo.sv
// First-word-fall-through sync FIFO for tagged pixels; full/empty come from
// the extra pointer bit. A push into a full FIFO is accepted only with a pop.
module rx_pixel_fifo
  import lcd_de_capture_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [TAG_W-1:0] din,
  input  logic             pop,
  output logic [TAG_W-1:0] dout,
  output logic             empty,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [TAG_W-1:0] mem_q [DEPTH];
  logic [TAG_W-1:0] mem_d [DEPTH];
  logic             full, do_push, do_pop;

  always_comb begin
    empty   = (wr_q == rd_q);
    full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    drop    = push && full && !do_pop;
    dout    = empty ? '0 : mem_q[rd_q[AW-1:0]];
  end

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (do_push) begin
      mem_d[wr_q[AW-1:0]] = din;
      wr_d                = wr_q + 1'b1;
    end
    if (do_pop) rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      mem_q <= '{default: '0};
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/lcd_de_capture.sv
// DE-only timing recovery for the parallel RGB panel bus: tags each active
// pixel with x/y/sof/eol, streams it out through a small FIFO, measures geometry.
module lcd_de_capture
  import lcd_de_capture_pkg::*;
#(
  parameter int VBLANK_MIN = 1024,
  parameter int FIFO_DEPTH = 4,
  parameter int EXP_WIDTH  = 640,
  parameter int EXP_HEIGHT = 480
) (
  input  logic        pixel_clk,
  input  logic        rst,
  input  logic        enb_in,
  input  logic [23:0] rgb_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] out_pixel,
  output logic [9:0]  out_x,
  output logic [9:0]  out_y,
  output logic        out_sof,
  output logic        out_eol,
  output logic [9:0]  meas_width,
  output logic [9:0]  meas_height,
  output logic        meas_valid,
  output logic        locked,
  output logic        err_width,
  output logic        err_overflow
);

  // state  | meaning
  // SYNC   | after reset, waiting for a full blanking gap; nothing captured
  // VBLANK | between frames; next DE high is pixel (0,0)
  // LINE   | inside an active line, one pixel per DE-high cycle
  // HGAP   | DE low between lines; long enough low run ends the frame

  localparam int GAP_W = $clog2(VBLANK_MIN + 1);
  localparam logic [GAP_W-1:0] GAP_END = GAP_W'(VBLANK_MIN);

  rx_state_e          state_q, state_d;
  logic               de_q, de_d;
  logic [23:0]        rgb_q, rgb_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  pix_tag_t           tag_q, tag_d;
  logic               tag_vld_q, tag_vld_d;
  logic [COORD_W-1:0] meas_width_q, meas_width_d, meas_height_q, meas_height_d;
  logic               meas_valid_q, meas_valid_d;
  logic               locked_q, locked_d, frame_ok_q, frame_ok_d;
  logic               err_width_q, err_width_d, err_overflow_q, err_overflow_d;

  logic               gap_hit, cap, cap_sof;
  logic [COORD_W-1:0] cap_x, cap_y;
  logic [COORD_W:0]   y_plus;
  pix_tag_t           push_data, head;
  logic               fifo_empty, fifo_drop;

  always_comb begin
    de_d    = enb_in;
    rgb_d   = rgb_in;
    // gap_d includes the current cycle, so a run of exactly VBLANK_MIN low
    // cycles ends the frame even if DE rises on the very next cycle.
    gap_d   = de_q ? '0 : ((gap_q == GAP_END) ? gap_q : gap_q + 1'b1);
    gap_hit = (gap_d == GAP_END);
    y_plus  = {1'b0, y_q} + 1'b1;

    state_d        = state_q;
    x_d            = x_q;
    y_d            = y_q;
    cap            = 1'b0;
    cap_x          = '0;
    cap_y          = '0;
    cap_sof        = 1'b0;
    meas_width_d   = meas_width_q;
    meas_height_d  = meas_height_q;
    meas_valid_d   = 1'b0;
    locked_d       = locked_q;
    frame_ok_d     = frame_ok_q;
    err_width_d    = err_width_q;
    err_overflow_d = err_overflow_q | fifo_drop;

    case (state_q)
      ST_SYNC: begin
        if (gap_hit) begin
          state_d    = ST_VBLANK;
          frame_ok_d = 1'b1;
        end
      end
      ST_VBLANK: begin
        if (de_q) begin
          state_d = ST_LINE;
          cap     = 1'b1;
          cap_sof = 1'b1;
          x_d     = 10'd1;
          y_d     = '0;
        end
      end
      ST_LINE: begin
        if (de_q) begin
          cap   = 1'b1;
          cap_x = x_q;
          cap_y = y_q;
          if (x_q == COORD_MAX) err_width_d = 1'b1;
          x_d = sat_inc(x_q);
        end else begin
          state_d      = ST_HGAP;
          meas_width_d = x_q;
          if (x_q != COORD_W'(EXP_WIDTH)) begin
            err_width_d = 1'b1;
            frame_ok_d  = 1'b0;
          end
        end
      end
      ST_HGAP: begin
        if (de_q) begin
          state_d = ST_LINE;
          cap     = 1'b1;
          cap_y   = sat_inc(y_q);
          y_d     = sat_inc(y_q);
          x_d     = 10'd1;
        end else if (gap_hit) begin
          state_d       = ST_VBLANK;
          meas_height_d = sat_inc(y_q);
          meas_valid_d  = 1'b1;
          locked_d      = frame_ok_q && (y_plus == (COORD_W + 1)'(EXP_HEIGHT));
          frame_ok_d    = 1'b1;
        end
      end
      default: state_d = ST_SYNC;
    endcase

    tag_vld_d = cap;
    tag_d     = cap ? '{rgb: rgb_q, x: cap_x, y: cap_y, sof: cap_sof, eol: 1'b0} : tag_q;
  end

  // The tag register delays each pixel one cycle so its eol can be taken
  // from the DE sample that follows it.
  always_comb begin
    push_data     = tag_q;
    push_data.eol = ~de_q;
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state_q        <= ST_SYNC;
      de_q           <= 1'b0;
      rgb_q          <= '0;
      gap_q          <= '0;
      x_q            <= '0;
      y_q            <= '0;
      tag_q          <= '0;
      tag_vld_q      <= 1'b0;
      meas_width_q   <= '0;
      meas_height_q  <= '0;
      meas_valid_q   <= 1'b0;
      locked_q       <= 1'b0;
      frame_ok_q     <= 1'b1;
      err_width_q    <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      de_q           <= de_d;
      rgb_q          <= rgb_d;
      gap_q          <= gap_d;
      x_q            <= x_d;
      y_q            <= y_d;
      tag_q          <= tag_d;
      tag_vld_q      <= tag_vld_d;
      meas_width_q   <= meas_width_d;
      meas_height_q  <= meas_height_d;
      meas_valid_q   <= meas_valid_d;
      locked_q       <= locked_d;
      frame_ok_q     <= frame_ok_d;
      err_width_q    <= err_width_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  rx_pixel_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (pixel_clk),
    .rst  (rst),
    .push (tag_vld_q),
    .din  (push_data),
    .pop  (out_ready),
    .dout (head),
    .empty(fifo_empty),
    .drop (fifo_drop)
  );

  assign out_valid    = ~fifo_empty;
  assign out_pixel    = head.rgb;
  assign out_x        = head.x;
  assign out_y        = head.y;
  assign out_sof      = head.sof;
  assign out_eol      = head.eol;
  assign meas_width   = meas_width_q;
  assign meas_height  = meas_height_q;
  assign meas_valid   = meas_valid_q;
  assign locked       = locked_q;
  assign err_width    = err_width_q;
  assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_lcd_de_capture.sv
// Directed bench for lcd_de_capture with a scaled-down 16x4 panel timing.
module tb_lcd_de_capture;

  localparam int VBM = 20;
  localparam int W   = 16;
  localparam int H   = 4;
  localparam int HB  = 6;
  localparam int VB  = 30;

  logic        pixel_clk = 1'b0;
  logic        rst, enb_in, out_ready;
  logic [23:0] rgb_in;
  logic        out_valid, out_sof, out_eol, meas_valid, locked, err_width, err_overflow;
  logic [23:0] out_pixel;
  logic [9:0]  out_x, out_y, meas_width, meas_height;

  lcd_de_capture #(
    .VBLANK_MIN(VBM),
    .FIFO_DEPTH(4),
    .EXP_WIDTH (W),
    .EXP_HEIGHT(H)
  ) dut (
    .pixel_clk   (pixel_clk),
    .rst         (rst),
    .enb_in      (enb_in),
    .rgb_in      (rgb_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pixel   (out_pixel),
    .out_x       (out_x),
    .out_y       (out_y),
    .out_sof     (out_sof),
    .out_eol     (out_eol),
    .meas_width  (meas_width),
    .meas_height (meas_height),
    .meas_valid  (meas_valid),
    .locked      (locked),
    .err_width   (err_width),
    .err_overflow(err_overflow)
  );

  always #5 pixel_clk = ~pixel_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int mv_cnt = 0;
  int mv_base;
  int fid;
  bit cap_en;
  logic [45:0] rx_q[$];
  logic [45:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  always @(negedge pixel_clk) begin
    if (out_valid && out_ready) rx_q.push_back({out_pixel, out_x, out_y, out_sof, out_eol});
    if (meas_valid) mv_cnt++;
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge pixel_clk); #1;
      enb_in = 1'b0;
      rgb_in = '0;
    end
  endtask

  // With out_ready low for 10 cycles starting at pixel stall_at, the FIFO
  // holds one pixel in flight plus three more, so pixels stall_at+1..+7 drop.
  task automatic line(input int w, input int y, input int gap, input int stall_at);
    for (int x = 0; x < w; x++) begin
      @(posedge pixel_clk); #1;
      enb_in = 1'b1;
      rgb_in = {8'(fid), 8'(y), 8'(x)};
      if (x == stall_at) out_ready = 1'b0;
      if (x == stall_at + 10) out_ready = 1'b1;
      if (cap_en && !(stall_at >= 0 && x >= stall_at + 1 && x <= stall_at + 7))
        exp_q.push_back({rgb_in, 10'(x), 10'(y), (x == 0 && y == 0), (x == w - 1)});
    end
    idle(gap);
  endtask

  task automatic frame(input int short_line, input int stall_line);
    for (int y = 0; y < H; y++)
      line((y == short_line) ? W - 1 : W, y, (y == H - 1) ? VB : HB, (y == stall_line) ? 4 : -1);
    fid++;
  endtask

  task automatic cmp_stream(input string tag);
    chk({tag, "_count"}, 64'(rx_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), 64'(rx_q[i]), 64'(exp_q[i]));
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 0);
    chk({tag, "_pixel"}, 64'(out_pixel), 0);
    chk({tag, "_mw"}, 64'(meas_width), 0);
    chk({tag, "_mh"}, 64'(meas_height), 0);
    chk({tag, "_mv"}, 64'(meas_valid), 0);
    chk({tag, "_locked"}, 64'(locked), 0);
    chk({tag, "_errw"}, 64'(err_width), 0);
    chk({tag, "_errov"}, 64'(err_overflow), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; enb_in = 1'b0; rgb_in = '0; out_ready = 1'b1; cap_en = 1'b0; fid = 1;
    repeat (3) @(posedge pixel_clk);
    #1;
    chk_zero("rst");
    rst = 1'b0;

    // first frame after reset is skipped, second one is captured in full
    frame(-1, -1);
    chk("t1_skip_pix", 64'(rx_q.size()), 0);
    chk("t1_skip_mv", 64'(mv_cnt), 0);
    cap_en = 1'b1;
    frame(-1, -1);
    cmp_stream("t1_pix");
    chk("t1_mv", 64'(mv_cnt), 1);
    chk("t1_mw", 64'(meas_width), 16);
    chk("t1_mh", 64'(meas_height), 4);
    chk("t1_locked", 64'(locked), 1);
    chk("t1_errw", 64'(err_width), 0);
    chk("t1_errov", 64'(err_overflow), 0);

    // gap of VBLANK_MIN-1 stays a line gap; exactly VBLANK_MIN ends the frame
    line(W, 0, HB, -1); line(W, 1, VBM - 1, -1); line(W, 2, HB, -1); line(W, 3, VB, -1); fid++;
    cmp_stream("t6_gap19");
    chk("t6_mv19", 64'(mv_cnt), 2);
    chk("t6_mh19", 64'(meas_height), 4);
    chk("t6_locked19", 64'(locked), 1);
    line(W, 0, HB, -1); line(W, 1, VBM, -1);
    idle(3);
    chk("t6_mv20", 64'(mv_cnt), 3);
    chk("t6_mh20", 64'(meas_height), 2);
    chk("t6_locked20", 64'(locked), 0);
    line(W, 0, HB, -1); line(W, 1, VB, -1); fid++;
    cmp_stream("t6_split");
    chk("t6_mv_split", 64'(mv_cnt), 4);

    // short line sets sticky err_width and breaks lock for one frame
    line(W, 0, HB, -1); line(W - 1, 1, HB, -1);
    chk("t2_mw_short", 64'(meas_width), 15);
    chk("t2_errw", 64'(err_width), 1);
    line(W, 2, HB, -1); line(W, 3, VB, -1); fid++;
    chk("t2_mw_next", 64'(meas_width), 16);
    chk("t2_locked_bad", 64'(locked), 0);
    cmp_stream("t2_pix");
    frame(-1, -1);
    cmp_stream("t2_clean");
    chk("t2_locked_ok", 64'(locked), 1);
    chk("t2_errw_sticky", 64'(err_width), 1);
    chk("t2_mv", 64'(mv_cnt), 6);

    // consumer stall mid-line overflows the FIFO
    frame(-1, 1);
    cmp_stream("t3_pix");
    chk("t3_errov", 64'(err_overflow), 1);
    chk("t3_locked", 64'(locked), 1);

    // single tagged pixel latency: out_valid rises three cycles after input
    for (int x = 0; x < W; x++) begin
      @(posedge pixel_clk); #1;
      if (x == 1 || x == 2) chk($sformatf("t4_lat%0d", x), 64'(out_valid), 0);
      if (x == 3) begin
        chk("t4_valid", 64'(out_valid), 1);
        chk("t4_pixel", 64'(out_pixel), 64'h00A5C3E7);
        chk("t4_sof", 64'(out_sof), 1);
        chk("t4_eol", 64'(out_eol), 0);
        chk("t4_xy", 64'({out_x, out_y}), 0);
      end
      enb_in = 1'b1;
      rgb_in = (x == 0) ? 24'hA5C3E7 : {8'(fid), 8'd0, 8'(x)};
      exp_q.push_back({rgb_in, 10'(x), 10'd0, (x == 0), (x == W - 1)});
    end
    idle(HB); line(W, 1, HB, -1); line(W, 2, HB, -1); line(W, 3, VB, -1); fid++;
    cmp_stream("t4_pix");

    // reset mid-frame: everything clears, partial frame is never emitted
    line(W, 0, HB, -1); line(W, 1, HB, -1);
    cmp_stream("t5_pre");
    cap_en = 1'b0;
    line(8, 2, 0, -1);
    @(posedge pixel_clk); #1;
    rst = 1'b1;
    @(posedge pixel_clk); #1;
    rst = 1'b0;
    chk_zero("t5_rst");
    rx_q.delete();
    mv_base = mv_cnt;
    line(8, 2, HB, -1); line(W, 3, VB, -1); fid++;
    chk("t5_nopix", 64'(rx_q.size()), 0);
    chk("t5_nomv", 64'(mv_cnt - mv_base), 0);
    cap_en = 1'b1;
    frame(-1, -1);
    cmp_stream("t5_post");
    chk("t5_mv", 64'(mv_cnt - mv_base), 1);
    chk("t5_locked", 64'(locked), 1);
    chk("t5_errw", 64'(err_width), 0);
    chk("t5_errov", 64'(err_overflow), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
